// File: rtl/rand_chk_pkg.sv
// rand_chk_pkg: shared xorshift32 constants, generator seed and checker state encoding.
// Used by the rand generator and the rand_chk checker so both agree on the polynomial.
package rand_chk_pkg;

    localparam int DATA_W  = 32;
    localparam int XS_SH_A = 13;
    localparam int XS_SH_B = 17;
    localparam int XS_SH_C = 5;

    localparam logic [DATA_W-1:0] RAND_SEED = 32'hCDA9D4AF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/rand_chk_if.sv
// rand_chk_if: received word stream into the checker plus its lock/error status outputs.
// The link side drives in_valid/in_data; the checker drives the status and statistics.
interface rand_chk_if #(
    parameter int CNT_W = 16
);
    logic                            in_valid;
    logic [rand_chk_pkg::DATA_W-1:0] in_data;
    logic                            locked;
    logic                            err_pulse;
    logic [CNT_W-1:0]                err_cnt;
    logic [CNT_W-1:0]                word_cnt;

    modport master (
        output in_valid, in_data,
        input  locked, err_pulse, err_cnt, word_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output locked, err_pulse, err_cnt, word_cnt
    );

endinterface

// File: rtl/rand_chk_xorshift_step.sv
// rand_chk_xorshift_step: combinational xorshift32 next-word function.
// Single definition of the shift polynomial shared by generator and checker.
module rand_chk_xorshift_step
    import rand_chk_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    output logic [DATA_W-1:0] x_o
);

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

    always_comb begin
        s1  = x_i ^ (x_i << XS_SH_A);
        s2  = s1 ^ (s1 >> XS_SH_B);
        x_o = s2 ^ (s2 << XS_SH_C);
    end

endmodule

// File: rtl/rand_chk.sv
// rand_chk: self-synchronising xorshift32 stream checker reporting lock and error statistics.
// Build macro RAND_CHK_RESYNC_EN: LOSS_N consecutive mismatches while LOCKED force a return to HUNT.
module rand_chk
    import rand_chk_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    rand_chk_if.slave bus
);

    localparam int                 MATCH_W    = $clog2(LOCK_N + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);

    if (LOCK_N < 1 || LOSS_N < 1) begin : g_bad_param
        $error("rand_chk: LOCK_N and LOSS_N must be at least 1");
    end

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  pred_q, pred_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic               locked_q;
    logic               pulse_q, pulse_d;
    logic [DATA_W-1:0]  step_in;
    logic [DATA_W-1:0]  step_pred;

`ifdef RAND_CHK_RESYNC_EN
    localparam int                  CONSEC_W    = $clog2(LOSS_N + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_LAST = CONSEC_W'(LOSS_N - 1);
    logic [CONSEC_W-1:0] consec_q, consec_d;
`endif

    // Reseeding uses the received word; once locked the prediction free-runs from itself.
    rand_chk_xorshift_step u_step_in   (.x_i(bus.in_data), .x_o(step_in));
    rand_chk_xorshift_step u_step_pred (.x_i(pred_q),      .x_o(step_pred));

    always_comb begin
        // NOTE: every variable gets its default before any branch, so no path can infer a latch.
        state_d  = state_q;
        pred_d   = pred_q;
        match_d  = match_q;
        err_d    = err_q;
        word_d   = word_q;
        pulse_d  = 1'b0;
`ifdef RAND_CHK_RESYNC_EN
        consec_d = consec_q;
`endif
        if (clr) begin
            state_d  = HUNT;
            match_d  = '0;
            err_d    = '0;
            word_d   = '0;
`ifdef RAND_CHK_RESYNC_EN
            consec_d = '0;
`endif
        end else if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Zero is a fixed point of xorshift and can never seed a usable prediction.
                    if (bus.in_data != '0) begin
                        pred_d  = step_in;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (bus.in_data == '0) begin
                        state_d = HUNT;
                    end else if (bus.in_data == pred_q) begin
                        pred_d  = step_in;
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_LAST) state_d = LOCKED;
                    end else begin
                        pred_d  = step_in;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = step_pred;
                    if (word_q != '1) word_d = word_q + CNT_W'(1);
                    if (bus.in_data != pred_q) begin
                        pulse_d = 1'b1;
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
`ifdef RAND_CHK_RESYNC_EN
                        if (consec_q == CONSEC_LAST) begin
                            consec_d = '0;
                            state_d  = HUNT;
                        end else begin
                            consec_d = consec_q + CONSEC_W'(1);
                        end
`endif
                    end
`ifdef RAND_CHK_RESYNC_EN
                    else begin
                        consec_d = '0;
                    end
`endif
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            err_q    <= '0;
            word_q   <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            err_q    <= err_d;
            word_q   <= word_d;
            locked_q <= (state_d == LOCKED);
            pulse_q  <= pulse_d;
        end
    end

`ifdef RAND_CHK_RESYNC_EN
    always_ff @(posedge clk) begin
        if (!rst_n) consec_q <= '0;
        else        consec_q <= consec_d;
    end
`endif

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_cnt   = err_q;
    assign bus.word_cnt  = word_q;

endmodule

// File: tb/tb_rand_chk.sv
// tb_rand_chk: scoreboard bench for rand_chk; a full-width and a 4-bit-counter instance see one stream.
// The stimulus pushes the expected outputs of both instances each cycle; a monitor pops and compares.
module tb_rand_chk;
    import rand_chk_pkg::*;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 8;

    typedef struct {
        state_e      st;
        logic [31:0] pred;
        int          match;
        int          consec;
        int          err;
        int          word;
        bit          locked;
        bit          pulse;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "reset";
    pair_t exp_q[$];
    mdl_t  ma, mb;
    logic [31:0] g;

    always #5 clk = ~clk;

    rand_chk_if #(.CNT_W(16)) ifa ();
    rand_chk_if #(.CNT_W(4))  ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.in_data  = in_data;
    assign ifb.in_valid = in_valid;
    assign ifb.in_data  = in_data;

    rand_chk #(.CNT_W(16), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa)
    );
    rand_chk #(.CNT_W(4), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb)
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.st = HUNT; m.pred = '0; m.match = 0; m.consec = 0;
        m.err = 0; m.word = 0; m.locked = 1'b0; m.pulse = 1'b0;
        return m;
    endfunction

    // Behavioural reference of one clock edge; cmax is the counter saturation value.
    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit c, input bit v,
                                      input logic [31:0] d, input int cmax);
        mdl_t n;
        n = m;
        n.pulse = 1'b0;
        if (!r || c) begin
            n.st = HUNT; n.match = 0; n.consec = 0; n.err = 0; n.word = 0; n.locked = 1'b0;
            return n;
        end
        if (v) begin
            case (m.st)
                HUNT: if (d != 0) begin
                    n.pred = xs(d); n.match = 0; n.st = VERIFY;
                end
                VERIFY: begin
                    if (d == 0) n.st = HUNT;
                    else if (d == m.pred) begin
                        n.pred = xs(d); n.match = m.match + 1;
                        if (n.match == LOCK_N) n.st = LOCKED;
                    end else begin
                        n.pred = xs(d); n.match = 0;
                    end
                end
                default: begin
                    n.pred = xs(m.pred);
                    if (m.word < cmax) n.word = m.word + 1;
                    if (d != m.pred) begin
                        n.pulse = 1'b1;
                        if (m.err < cmax) n.err = m.err + 1;
                        n.consec = m.consec + 1;
`ifdef RAND_CHK_RESYNC_EN
                        if (n.consec >= LOSS_N) begin
                            n.st = HUNT; n.consec = 0;
                        end
`endif
                    end else begin
                        n.consec = 0;
                    end
                end
            endcase
        end
        n.locked = (n.st == LOCKED);
        return n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, nm, act, exp);
        end
    endtask

    // Entered at a negedge: drive one cycle, queue the expected post-edge outputs, return at next negedge.
    task automatic tick(input bit r, input bit c, input bit v, input logic [31:0] d);
        pair_t p;
        rst_n = r; clr = c; in_valid = v; in_data = d;
        ma = mdl_step(ma, r, c, v, d, 65535);
        mb = mdl_step(mb, r, c, v, d, 15);
        p.a = ma;
        p.b = mb;
        exp_q.push_back(p);
        @(negedge clk);
    endtask

    task automatic good();
        tick(1'b1, 1'b0, 1'b1, g);
        g = xs(g);
    endtask

    task automatic bad(input logic [31:0] mask);
        tick(1'b1, 1'b0, 1'b1, g ^ mask);
        g = xs(g);
    endtask

    // Monitor: outputs are registered, so compare just after each active edge.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                check("a_locked",   ifa.locked,    p.a.locked);
                check("a_err_pulse", ifa.err_pulse, p.a.pulse);
                check("a_err_cnt",  ifa.err_cnt,   p.a.err);
                check("a_word_cnt", ifa.word_cnt,  p.a.word);
                check("b_locked",   ifb.locked,    p.b.locked);
                check("b_err_pulse", ifb.err_pulse, p.b.pulse);
                check("b_err_cnt",  ifb.err_cnt,   p.b.err);
                check("b_word_cnt", ifb.word_cnt,  p.b.word);
            end
        end
    end

    initial begin
        int nv;
        ma = mdl_init();
        mb = mdl_init();
        g  = RAND_SEED;
        @(negedge clk);

        // Reset with in_valid high: the word must be ignored.
        repeat (3) tick(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        check("rst_locked", ifa.locked, 0);
        check("rst_err", ifa.err_cnt, 0);
        check("rst_word", ifa.word_cnt, 0);

        // Zero words in HUNT keep it hunting; then lock on seed + 4 matches.
        phase = "lock";
        repeat (2) tick(1'b1, 1'b0, 1'b1, 32'h0);
        repeat (4) good();
        check("locked_before_4th_match", ifa.locked, 0);
        good();
        check("locked_after_4th_match", ifa.locked, 1);
        check("word_at_lock", ifa.word_cnt, 0);
        repeat (10) good();
        check("word_after_10", ifa.word_cnt, 10);
        check("err_clean", ifa.err_cnt, 0);

        // Single bit flip while locked.
        phase = "bitflip";
        bad(32'h1);
        check("pulse_on_error", ifa.err_pulse, 1);
        check("err_one", ifa.err_cnt, 1);
        check("still_locked", ifa.locked, 1);
        good();
        check("pulse_one_cycle", ifa.err_pulse, 0);
        check("err_after_good", ifa.err_cnt, 1);
        check("word_12", ifa.word_cnt, 12);

        // Gapped stream from a cleared checker, about 30% valid.
        phase = "gaps";
        tick(1'b1, 1'b1, 1'b1, g);
        nv = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                good();
                nv++;
            end else begin
                tick(1'b1, 1'b0, 1'b0, $urandom);
            end
        end
        check("gap_locked", ifa.locked, 1);
        check("gap_err", ifa.err_cnt, 0);
        check("gap_word", ifa.word_cnt, nv - 5);

        // Corrupt third word during acquisition: two reseeds, then LOCK_N matches.
        phase = "verify_restart";
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        good();
        good();
        bad(32'h100);
        repeat (4) good();
        check("not_locked_yet", ifa.locked, 0);
        good();
        check("relocked", ifa.locked, 1);
        check("vr_err", ifa.err_cnt, 0);

        // Eight consecutive bad words while locked.
        phase = "loss";
        repeat (8) bad(32'hFFFF_0000);
        check("loss_err", ifa.err_cnt, 8);
`ifdef RAND_CHK_RESYNC_EN
        check("loss_unlocked", ifa.locked, 0);
`else
        check("loss_still_locked", ifa.locked, 1);
`endif
        repeat (5) good();
        check("loss_relocked", ifa.locked, 1);
        check("loss_err_kept", ifa.err_cnt, 8);

        // Saturation on the 4-bit instance, then clear and relock.
        phase = "clr_sat";
        tick(1'b1, 1'b1, 1'b1, g);
        repeat (5) good();
        for (int i = 0; i < 20; i++) begin
            bad(32'h8000_0000);
            good();
        end
        check("b_err_sat", ifb.err_cnt, 15);
        check("b_word_sat", ifb.word_cnt, 15);
        check("b_locked", ifb.locked, 1);
        check("a_err_20", ifa.err_cnt, 20);
        check("a_word_40", ifa.word_cnt, 40);
        tick(1'b1, 1'b1, 1'b1, g);
        check("clr_locked", ifb.locked, 0);
        check("clr_err", ifb.err_cnt, 0);
        check("clr_word", ifb.word_cnt, 0);
        check("clr_a_err", ifa.err_cnt, 0);
        repeat (5) good();
        check("clr_relock", ifb.locked, 1);

        phase = "drain";
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
